// File: rtl/flit_input_arbiter_pkg.sv
// Shared types for the flit input arbiter: flit payload, flit kinds, FSM states and owner codes.
package types;

    localparam int unsigned DEST_W    = 4;
    localparam int unsigned PAYLOAD_W = 26;

    typedef enum logic [1:0] {
        HEAD   = 2'd0,
        BODY   = 2'd1,
        TAIL   = 2'd2,
        SINGLE = 2'd3
    } flittype_t;

    typedef struct packed {
        flittype_t              ftype;
        logic [DEST_W-1:0]      dest;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCK_CPU = 2'd1,
        LOCK_RX  = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_CPU  = 2'd1;
    localparam logic [1:0] OWNER_RX   = 2'd2;

    // HEAD and SINGLE both open a packet and may win arbitration.
    function automatic logic starts_packet(flit_t f);
        return (f.ftype == HEAD) || (f.ftype == SINGLE);
    endfunction

    function automatic logic [1:0] owner_of(arb_state_t s);
        case (s)
            LOCK_CPU: return OWNER_CPU;
            LOCK_RX:  return OWNER_RX;
            default:  return OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/flit_input_arbiter_if.sv
// Flit handshake bundle between the two requesters, the arbiter and the router.
interface flit_input_arbiter_if;
    import types::*;

    flit_t cpu_flit;
    logic  cpu_flit_valid;
    logic  cpu_flit_ready;
    flit_t rx_flit;
    logic  rx_flit_valid;
    logic  rx_flit_ready;
    flit_t transfered_flit;
    logic  transfered_flit_valid;
    logic  transfered_flit_ready;
    flit_t transfered_head_flit;

    modport master (
        output cpu_flit, cpu_flit_valid, rx_flit, rx_flit_valid, transfered_flit_ready,
        input  cpu_flit_ready, rx_flit_ready, transfered_flit, transfered_flit_valid,
               transfered_head_flit
    );

    modport slave (
        input  cpu_flit, cpu_flit_valid, rx_flit, rx_flit_valid, transfered_flit_ready,
        output cpu_flit_ready, rx_flit_ready, transfered_flit, transfered_flit_valid,
               transfered_head_flit
    );

endinterface

// File: rtl/flit_input_arbiter_rr_arbiter2.sv
// Two-input round-robin: bit 0 = CPU, bit 1 = RX; grant_c[i] means "i wins if it requests".
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] upd,
    output logic [1:0] grant_c
);

    logic last_grant_q;  // 0 = CPU, 1 = RX

    // Eligibility ignores a requester's own request so readies never loop back on valid.
    assign grant_c[0] = !req[1] || last_grant_q;
    assign grant_c[1] = !req[0] || !last_grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b0;
        end else if (|upd) begin
            last_grant_q <= upd[1];
        end
    end

endmodule

// File: rtl/flit_input_arbiter.sv
// Packet-atomic CPU/RX arbiter in front of the router, with orphan dropping.
// Optional lock timeout is compiled in with `define PACKET_TIMEOUT_EN.
module flit_input_arbiter
    import types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned DROP_CNT_W     = 8
) (
    input  logic                  nocclk,
    input  logic                  rst_n,
    flit_input_arbiter_if.slave   bus,
    output logic [1:0]            owner,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  timeout_pulse
);

    localparam int unsigned SUM_W = DROP_CNT_W + 1;

    arb_state_t       state_q, state_d;
    logic             out_valid_q;
    flit_t            out_flit_q, head_flit_q;
    logic             can_load_c, cpu_head_c, rx_head_c;
    logic [1:0]       req_c, win_c, upd_c;
    logic             cpu_ready_c, rx_ready_c, fwd_c, cpu_drop_c, rx_drop_c;
    flit_t            fwd_flit_c;
    logic [SUM_W-1:0] drop_sum_c;

    assign can_load_c = !out_valid_q || bus.transfered_flit_ready;
    assign cpu_head_c = starts_packet(bus.cpu_flit);
    assign rx_head_c  = starts_packet(bus.rx_flit);
    assign req_c      = {bus.rx_flit_valid && rx_head_c, bus.cpu_flit_valid && cpu_head_c};

    rr_arbiter2 u_rr (
        .clk     (nocclk),
        .rst_n   (rst_n),
        .req     (req_c),
        .upd     (upd_c),
        .grant_c (win_c)
    );

`ifdef PACKET_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_c;
`endif

    // Next state, input readies, forwarding and orphan detection.
    always_comb begin
        state_d     = state_q;
        cpu_ready_c = 1'b0;
        rx_ready_c  = 1'b0;
        fwd_c       = 1'b0;
        fwd_flit_c  = bus.cpu_flit;
        upd_c       = 2'b00;
        cpu_drop_c  = 1'b0;
        rx_drop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_ready_c = cpu_head_c ? (win_c[0] && can_load_c) : 1'b1;
                rx_ready_c  = rx_head_c  ? (win_c[1] && can_load_c) : 1'b1;
                cpu_drop_c  = bus.cpu_flit_valid && !cpu_head_c;
                rx_drop_c   = bus.rx_flit_valid  && !rx_head_c;
                if (bus.cpu_flit_valid && cpu_head_c && cpu_ready_c) begin
                    fwd_c      = 1'b1;
                    fwd_flit_c = bus.cpu_flit;
                    upd_c      = 2'b01;
                    if (bus.cpu_flit.ftype == HEAD) state_d = LOCK_CPU;
                end else if (bus.rx_flit_valid && rx_head_c && rx_ready_c) begin
                    fwd_c      = 1'b1;
                    fwd_flit_c = bus.rx_flit;
                    upd_c      = 2'b10;
                    if (bus.rx_flit.ftype == HEAD) state_d = LOCK_RX;
                end
            end
            LOCK_CPU: begin
                cpu_ready_c = can_load_c;
                if (bus.cpu_flit_valid && can_load_c) begin
                    fwd_c      = 1'b1;
                    fwd_flit_c = bus.cpu_flit;
                    if (bus.cpu_flit.ftype != BODY) state_d = IDLE;
                end
            end
            LOCK_RX: begin
                rx_ready_c = can_load_c;
                if (bus.rx_flit_valid && can_load_c) begin
                    fwd_c      = 1'b1;
                    fwd_flit_c = bus.rx_flit;
                    if (bus.rx_flit.ftype != BODY) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef PACKET_TIMEOUT_EN
        // An owner flit accepted in the expiry cycle wins over the timeout.
        tmo_c = (state_q != IDLE) && !fwd_c && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
        if (tmo_c) state_d = IDLE;
`endif
    end

    assign bus.cpu_flit_ready        = cpu_ready_c;
    assign bus.rx_flit_ready         = rx_ready_c;
    assign bus.transfered_flit       = out_flit_q;
    assign bus.transfered_flit_valid = out_valid_q;
    assign bus.transfered_head_flit  = head_flit_q;

    assign drop_sum_c = SUM_W'(drop_count) + SUM_W'(cpu_drop_c) + SUM_W'(rx_drop_c);

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner       <= OWNER_NONE;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            head_flit_q <= '0;
            drop_count  <= '0;
        end else begin
            state_q <= state_d;
            owner   <= owner_of(state_d);
            if (fwd_c) begin
                out_valid_q <= 1'b1;
                out_flit_q  <= fwd_flit_c;
                if (starts_packet(fwd_flit_c)) head_flit_q <= fwd_flit_c;
            end else if (bus.transfered_flit_ready) begin
                out_valid_q <= 1'b0;
            end
            drop_count <= drop_sum_c[DROP_CNT_W] ? '1 : drop_sum_c[DROP_CNT_W-1:0];
        end
    end

`ifdef PACKET_TIMEOUT_EN
    // Stall counter runs only while locked and no owner flit moves.
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q     <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= tmo_c;
            if (state_q == IDLE || fwd_c || tmo_c) tmo_cnt_q <= '0;
            else                                    tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end
`else
    assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_flit_input_arbiter.sv
// Directed bench for flit_input_arbiter: arbitration, locking, stalls, orphans, reset, timeout.
module tb_flit_input_arbiter;
    import types::*;

`ifdef PACKET_TIMEOUT_EN
    localparam int unsigned TB_TMO = 4;
`else
    localparam int unsigned TB_TMO = 256;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] owner;
    logic [7:0] drop_count;
    logic       timeout_pulse;
    int         n_checks = 0;
    int         n_errors = 0;

    flit_input_arbiter_if bus ();

    flit_input_arbiter #(.TIMEOUT_CYCLES(TB_TMO), .DROP_CNT_W(8)) dut (
        .nocclk        (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .owner         (owner),
        .drop_count    (drop_count),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic flit_t mk(input flittype_t t, input int unsigned id);
        flit_t f;
        f.ftype   = t;
        f.dest    = 4'h3;
        f.payload = PAYLOAD_W'(id);
        return f;
    endfunction

    task automatic cpu(input flittype_t t, input int unsigned id, input logic v);
        bus.cpu_flit       = mk(t, id);
        bus.cpu_flit_valid = v;
    endtask

    task automatic rx(input flittype_t t, input int unsigned id, input logic v);
        bus.rx_flit       = mk(t, id);
        bus.rx_flit_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input flit_t f);
        check({tag, "_flit"},  64'(bus.transfered_flit), 64'(f));
        check({tag, "_valid"}, 64'(bus.transfered_flit_valid), 64'(1));
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        cpu(BODY, 0, 1'b0);
        rx(BODY, 0, 1'b0);
        bus.transfered_flit_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_owner", 64'(owner), 64'(0));
        check("rst_valid", 64'(bus.transfered_flit_valid), 64'(0));
        check("rst_flit",  64'(bus.transfered_flit), 64'(0));
        check("rst_head",  64'(bus.transfered_head_flit), 64'(0));
        check("rst_drop",  64'(drop_count), 64'(0));
        check("rst_tmo",   64'(timeout_pulse), 64'(0));
        rst_n = 1'b1;

        // First tie after reset goes to RX; RX packet streams back-to-back.
        cpu(HEAD, 'h10, 1'b1);
        rx(HEAD, 'h20, 1'b1);
        #1;
        check("tie1_rx_rdy",  64'(bus.rx_flit_ready), 64'(1));
        check("tie1_cpu_rdy", 64'(bus.cpu_flit_ready), 64'(0));
        tick();
        chk_out("rx_head", mk(HEAD, 'h20));
        check("rx_owner", 64'(owner), 64'(2));
        check("rx_headreg", 64'(bus.transfered_head_flit), 64'(mk(HEAD, 'h20)));
        rx(BODY, 'h21, 1'b1);
        #1;
        check("lockrx_cpu_rdy", 64'(bus.cpu_flit_ready), 64'(0));
        check("lockrx_rx_rdy",  64'(bus.rx_flit_ready), 64'(1));
        tick();
        chk_out("rx_body1", mk(BODY, 'h21));
        rx(BODY, 'h22, 1'b1);
        tick();
        chk_out("rx_body2", mk(BODY, 'h22));
        check("rx_owner2", 64'(owner), 64'(2));
        rx(TAIL, 'h23, 1'b1);
        #1;
        check("rxtail_cpu_rdy", 64'(bus.cpu_flit_ready), 64'(0));
        tick();
        chk_out("rx_tail", mk(TAIL, 'h23));
        check("rxtail_owner", 64'(owner), 64'(0));
        check("rxtail_headreg", 64'(bus.transfered_head_flit), 64'(mk(HEAD, 'h20)));
        rx(BODY, 0, 1'b0);
        #1;
        check("cpu_after_tail_rdy", 64'(bus.cpu_flit_ready), 64'(1));
        tick();
        chk_out("cpu_head", mk(HEAD, 'h10));
        check("cpu_owner", 64'(owner), 64'(1));
        check("cpu_headreg", 64'(bus.transfered_head_flit), 64'(mk(HEAD, 'h10)));

        // Router stalls for three cycles mid-packet.
        cpu(BODY, 'h11, 1'b1);
        tick();
        chk_out("cpu_body1", mk(BODY, 'h11));
        cpu(BODY, 'h12, 1'b1);
        rx(HEAD, 'h24, 1'b1);
        bus.transfered_flit_ready = 1'b0;
        #1;
        check("stall_cpu_rdy", 64'(bus.cpu_flit_ready), 64'(0));
        check("stall_rx_rdy",  64'(bus.rx_flit_ready), 64'(0));
        tick();
        for (int k = 0; k < 2; k++) begin
            chk_out("stall_hold", mk(BODY, 'h11));
            check("stall_cpu_rdy2", 64'(bus.cpu_flit_ready), 64'(0));
            tick();
        end
        bus.transfered_flit_ready = 1'b1;
        #1;
        chk_out("stall_end", mk(BODY, 'h11));
        check("unstall_cpu_rdy", 64'(bus.cpu_flit_ready), 64'(1));
        tick();
        chk_out("cpu_body2", mk(BODY, 'h12));
        cpu(TAIL, 'h13, 1'b1);
        tick();
        chk_out("cpu_tail", mk(TAIL, 'h13));
        check("cputail_owner", 64'(owner), 64'(0));

        // Tie with last_grant = CPU: RX SINGLE wins and FSM stays idle.
        cpu(HEAD, 'h14, 1'b1);
        rx(SINGLE, 'h24, 1'b1);
        #1;
        check("tie2_rx_rdy",  64'(bus.rx_flit_ready), 64'(1));
        check("tie2_cpu_rdy", 64'(bus.cpu_flit_ready), 64'(0));
        tick();
        chk_out("rx_single", mk(SINGLE, 'h24));
        check("single_head", 64'(bus.transfered_head_flit), 64'(mk(SINGLE, 'h24)));
        check("single_owner", 64'(owner), 64'(0));

        // Tie with last_grant = RX: CPU wins.
        rx(HEAD, 'h25, 1'b1);
        #1;
        check("tie3_cpu_rdy", 64'(bus.cpu_flit_ready), 64'(1));
        check("tie3_rx_rdy",  64'(bus.rx_flit_ready), 64'(0));
        tick();
        chk_out("tie3_out", mk(HEAD, 'h14));
        check("tie3_owner", 64'(owner), 64'(1));

        // HEAD while locked: forwarded, unlocks without re-lock.
        cpu(HEAD, 'h15, 1'b1);
        rx(BODY, 0, 1'b0);
        tick();
        chk_out("err_head", mk(HEAD, 'h15));
        check("err_headreg", 64'(bus.transfered_head_flit), 64'(mk(HEAD, 'h15)));
        check("err_owner", 64'(owner), 64'(0));

        // RX orphan dropped while CPU SINGLE arbitrates in the same cycle.
        cpu(SINGLE, 'h16, 1'b1);
        rx(BODY, 'h26, 1'b1);
        #1;
        check("mix_cpu_rdy", 64'(bus.cpu_flit_ready), 64'(1));
        check("mix_rx_rdy",  64'(bus.rx_flit_ready), 64'(1));
        tick();
        chk_out("mix_out", mk(SINGLE, 'h16));
        check("mix_drop", 64'(drop_count), 64'(1));
        cpu(BODY, 'h17, 1'b1);
        rx(TAIL, 'h27, 1'b1);
        #1;
        check("dbl_cpu_rdy", 64'(bus.cpu_flit_ready), 64'(1));
        check("dbl_rx_rdy",  64'(bus.rx_flit_ready), 64'(1));
        tick();
        check("dbl_drop", 64'(drop_count), 64'(3));
        check("dbl_valid", 64'(bus.transfered_flit_valid), 64'(0));

        // 300 CPU orphans saturate the drop counter.
        rx(BODY, 0, 1'b0);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            cpu(BODY, 'h100 + i, 1'b1);
            tick();
            if (bus.transfered_flit_valid !== 1'b0) bad++;
        end
        check("orphan_fwd", 64'(bad), 64'(0));
        check("orphan_sat", 64'(drop_count), 64'(255));
        rx(TAIL, 'h28, 1'b1);
        tick();
        check("orphan_sat2", 64'(drop_count), 64'(255));

        // Reset mid-packet, then the stranded TAIL is an orphan.
        cpu(HEAD, 'h30, 1'b1);
        rx(BODY, 0, 1'b0);
        tick();
        check("mid_owner", 64'(owner), 64'(1));
        chk_out("mid_head", mk(HEAD, 'h30));
        cpu(BODY, 'h31, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_owner", 64'(owner), 64'(0));
        check("mid_rst_valid", 64'(bus.transfered_flit_valid), 64'(0));
        check("mid_rst_flit",  64'(bus.transfered_flit), 64'(0));
        check("mid_rst_head",  64'(bus.transfered_head_flit), 64'(0));
        check("mid_rst_drop",  64'(drop_count), 64'(0));
        tick();
        rst_n = 1'b1;
        cpu(TAIL, 'h32, 1'b1);
        #1;
        check("stray_rdy", 64'(bus.cpu_flit_ready), 64'(1));
        tick();
        check("stray_drop",  64'(drop_count), 64'(1));
        check("stray_valid", 64'(bus.transfered_flit_valid), 64'(0));
        check("stray_owner", 64'(owner), 64'(0));

        // Stalled lock: timeout when enabled, held indefinitely otherwise.
        cpu(HEAD, 'h40, 1'b1);
        tick();
        check("tmo_lock_owner", 64'(owner), 64'(1));
        cpu(BODY, 0, 1'b0);
`ifdef PACKET_TIMEOUT_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            check("tmo_wait_pulse", 64'(timeout_pulse), 64'(0));
            check("tmo_wait_owner", 64'(owner), 64'(1));
        end
        tick();
        check("tmo_pulse", 64'(timeout_pulse), 64'(1));
        check("tmo_owner", 64'(owner), 64'(0));
        tick();
        check("tmo_pulse_end", 64'(timeout_pulse), 64'(0));
`else
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (owner !== 2'd1 || timeout_pulse !== 1'b0) bad++;
        end
        check("hold_lock", 64'(bad), 64'(0));
        check("hold_owner", 64'(owner), 64'(1));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
